// File: rtl/memoria_ram_dp.sv
// Simple dual-port RAM with a registered read port and a selectable read-during-write mode.
// A built-in clear sequencer fills the array with INIT_VAL after reset or when clear_i is pulsed.
module memoria_ram_dp #(
    parameter int             N            = 4,
    parameter int             M            = 4,
    parameter bit             RDW_MODE     = 1'b0,
    parameter bit             CLEAR_ON_RST = 1'b1,
    parameter logic [M-1:0]   INIT_VAL     = '0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  wr_addr_i,
    input  logic [M-1:0]  dato_write_i,
    input  logic          wren_i,
    input  logic [N-1:0]  rd_addr_i,
    input  logic          rden_i,
    output logic [M-1:0]  dato_read_o,
    output logic          rd_valid_o,
    input  logic          clear_i,
    output logic          busy_o
);

    localparam int           DEPTH     = 1 << N;
    localparam logic [0:0]   ST_RUN    = 1'b0;
    localparam logic [0:0]   ST_CLEAR  = 1'b1;
    localparam logic [N-1:0] LAST_ADDR = {N{1'b1}};

    logic [0:0]   state;
    logic [N-1:0] clr_ptr;
    logic [M-1:0] mem [DEPTH];

    logic         run_ok;
    logic         user_wr;
    logic         user_rd;
    logic         rdw_hit;
    logic         mem_we;
    logic [N-1:0] mem_waddr;
    logic [M-1:0] mem_wdata;

    logic [M-1:0] rd_data_p1;
    logic         vld_p1;

    // User ports are live only in RUN; a clear request in the same cycle wins over them.
    assign run_ok  = (state == ST_RUN) && !clear_i && !rst_i;
    assign user_wr = run_ok && wren_i;
    assign user_rd = run_ok && rden_i;
    assign rdw_hit = RDW_MODE && user_wr && (wr_addr_i == rd_addr_i);

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr_i;
        mem_wdata = dato_write_i;
        if (!rst_i && (state == ST_CLEAR)) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = INIT_VAL;
        end else if (user_wr) begin
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
            clr_ptr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    // Pointer parks on the last word instead of wrapping.
                    if (clr_ptr == LAST_ADDR) begin
                        state <= ST_RUN;
                    end else begin
                        clr_ptr <= clr_ptr + 1'b1;
                    end
                end
                default: begin
                    if (clear_i) begin
                        state   <= ST_CLEAR;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    // Storage: written by either the clear sequencer or the user write port, never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read stage p1: registered data plus its valid strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= user_rd;
            if (user_rd) begin
                rd_data_p1 <= rdw_hit ? dato_write_i : mem[rd_addr_i];
            end
        end
    end

    assign dato_read_o = rd_data_p1;
    assign rd_valid_o  = vld_p1;
    assign busy_o      = (state == ST_CLEAR);

endmodule

// File: tb/tb_memoria_ram_dp.sv
// Bench for memoria_ram_dp: three instances (old-data, write-through, no clear on reset)
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_memoria_ram_dp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Group A stimulus drives instances 0 and 1, group B drives instance 2.
    logic       a_rst = 1'b1, a_clr = 1'b0, a_we = 1'b0, a_re = 1'b0;
    logic [3:0] a_wa = '0, a_wd = '0, a_ra = '0;
    logic       b_rst = 1'b1, b_clr = 1'b0, b_we = 1'b0, b_re = 1'b0;
    logic [3:0] b_wa = '0, b_wd = '0, b_ra = '0;

    logic [3:0] o_rd [3];
    logic [2:0] o_vld;
    logic [2:0] o_busy;

    int checks = 0;
    int failures = 0;

    memoria_ram_dp #(.N(4), .M(4), .RDW_MODE(1'b0), .CLEAR_ON_RST(1'b1), .INIT_VAL(4'hA)) dut0 (
        .clk_i(clk), .rst_i(a_rst), .wr_addr_i(a_wa), .dato_write_i(a_wd), .wren_i(a_we),
        .rd_addr_i(a_ra), .rden_i(a_re), .dato_read_o(o_rd[0]), .rd_valid_o(o_vld[0]),
        .clear_i(a_clr), .busy_o(o_busy[0]));

    memoria_ram_dp #(.N(4), .M(4), .RDW_MODE(1'b1), .CLEAR_ON_RST(1'b1), .INIT_VAL(4'hA)) dut1 (
        .clk_i(clk), .rst_i(a_rst), .wr_addr_i(a_wa), .dato_write_i(a_wd), .wren_i(a_we),
        .rd_addr_i(a_ra), .rden_i(a_re), .dato_read_o(o_rd[1]), .rd_valid_o(o_vld[1]),
        .clear_i(a_clr), .busy_o(o_busy[1]));

    memoria_ram_dp #(.N(4), .M(4), .RDW_MODE(1'b0), .CLEAR_ON_RST(1'b0), .INIT_VAL(4'h3)) dut2 (
        .clk_i(clk), .rst_i(b_rst), .wr_addr_i(b_wa), .dato_write_i(b_wd), .wren_i(b_we),
        .rd_addr_i(b_ra), .rden_i(b_re), .dato_read_o(o_rd[2]), .rd_valid_o(o_vld[2]),
        .clear_i(b_clr), .busy_o(o_busy[2]));

    // Behavioural model: per instance, word contents with a known flag and a busy countdown.
    int         p_rdw [3]  = '{0, 1, 0};
    int         p_cor [3]  = '{1, 1, 0};
    logic [3:0] p_init [3] = '{4'hA, 4'hA, 4'h3};

    logic [3:0] m_mem [3][16];
    bit         m_known [3][16];
    int         m_busy [3];
    int         m_next [3];
    logic [3:0] m_rd [3];
    bit         m_rd_known [3];
    bit         m_vld [3];
    bit         m_live [3];

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_busy[k] = 0; m_next[k] = 0; m_rd[k] = '0; m_rd_known[k] = 0;
            m_vld[k] = 0; m_live[k] = 0;
            for (int a = 0; a < 16; a++) begin
                m_mem[k][a] = '0; m_known[k][a] = 0;
            end
        end
    end

    task automatic model_step(input int k, input bit rst, input bit clr, input bit we,
                              input logic [3:0] wa, input logic [3:0] wd,
                              input bit re, input logic [3:0] ra);
        if (rst) begin
            m_rd[k] = '0; m_rd_known[k] = 1; m_vld[k] = 0; m_live[k] = 1;
            m_busy[k] = (p_cor[k] != 0) ? 16 : 0;
            m_next[k] = 0;
        end else if (m_busy[k] > 0) begin
            m_mem[k][m_next[k]] = p_init[k];
            m_known[k][m_next[k]] = 1;
            m_next[k] = m_next[k] + 1;
            m_busy[k] = m_busy[k] - 1;
            m_vld[k] = 0;
        end else if (clr) begin
            m_busy[k] = 16; m_next[k] = 0; m_vld[k] = 0;
        end else begin
            m_vld[k] = re;
            if (re) begin
                if (p_rdw[k] != 0 && we && wa == ra) begin
                    m_rd[k] = wd; m_rd_known[k] = 1;
                end else begin
                    m_rd[k] = m_mem[k][ra]; m_rd_known[k] = m_known[k][ra];
                end
            end
            if (we) begin
                m_mem[k][wa] = wd; m_known[k][wa] = 1;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0, a_rst, a_clr, a_we, a_wa, a_wd, a_re, a_ra);
        model_step(1, a_rst, a_clr, a_we, a_wa, a_wd, a_re, a_ra);
        model_step(2, b_rst, b_clr, b_we, b_wa, b_wd, b_re, b_ra);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (m_live[k]) begin
                chk($sformatf("model_busy%0d", k), 32'(o_busy[k]), 32'(m_busy[k] > 0));
                chk($sformatf("model_vld%0d", k), 32'(o_vld[k]), 32'(m_vld[k]));
                if (m_rd_known[k])
                    chk($sformatf("model_rd%0d", k), 32'(o_rd[k]), 32'(m_rd[k]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until instance k drops busy; bounded so a stuck busy still ends the run.
    task automatic count_busy(input int k, input string name);
        int cnt;
        cnt = 0;
        while (o_busy[k] && cnt < 40) begin
            tick();
            cnt++;
        end
        chk(name, 32'(cnt), 32'd16);
    endtask

    task automatic read_a(input logic [3:0] addr);
        a_ra = addr; a_re = 1'b1;
        tick();
        a_re = 1'b0;
    endtask

    task automatic read_b(input logic [3:0] addr);
        b_ra = addr; b_re = 1'b1;
        tick();
        b_re = 1'b0;
    endtask

    initial begin
        // Reset with clear: 16 busy cycles, then every word reads INIT_VAL.
        tick();
        a_rst = 1'b0; b_rst = 1'b0;
        chk("rst_rd0", 32'(o_rd[0]), 32'h0);
        chk("rst_vld0", 32'(o_vld[0]), 32'h0);
        chk("rst_busy0", 32'(o_busy[0]), 32'h1);
        chk("rst_busy2", 32'(o_busy[2]), 32'h0);
        count_busy(0, "rst_busy_len0");
        chk("rst_busy_done1", 32'(o_busy[1]), 32'h0);
        for (int a = 0; a < 16; a++) begin
            read_a(4'(a));
            chk("init_rd", 32'(o_rd[0]), 32'hA);
            chk("init_vld", 32'(o_vld[0]), 32'h1);
        end

        // Write then read back, valid drops on the idle cycle with data held.
        a_wa = 4'd3; a_wd = 4'h5; a_we = 1'b1;
        tick();
        a_we = 1'b0;
        read_a(4'd3);
        chk("wr_rd_data", 32'(o_rd[0]), 32'h5);
        chk("wr_rd_vld", 32'(o_vld[0]), 32'h1);
        tick();
        chk("idle_vld", 32'(o_vld[0]), 32'h0);
        chk("idle_hold", 32'(o_rd[0]), 32'h5);

        // Read-during-write on the same address.
        a_wa = 4'd7; a_wd = 4'h2; a_we = 1'b1;
        tick();
        a_wd = 4'hC; a_ra = 4'd7; a_re = 1'b1;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk("rdw_old", 32'(o_rd[0]), 32'h2);
        chk("rdw_new", 32'(o_rd[1]), 32'hC);
        read_a(4'd7);
        chk("rdw_after0", 32'(o_rd[0]), 32'hC);
        chk("rdw_after1", 32'(o_rd[1]), 32'hC);

        // Different addresses in the same cycle stay independent in write-through mode.
        a_wa = 4'd8; a_wd = 4'h6; a_we = 1'b1; a_ra = 4'd3; a_re = 1'b1;
        tick();
        a_we = 1'b0; a_re = 1'b0;
        chk("rdw_diff1", 32'(o_rd[1]), 32'h5);

        // Clear beats a same-cycle write; pulses during busy are ignored.
        a_clr = 1'b1; a_wa = 4'd1; a_wd = 4'hF; a_we = 1'b1;
        tick();
        a_clr = 1'b0; a_we = 1'b0;
        chk("clr_busy", 32'(o_busy[0]), 32'h1);
        begin
            int cnt;
            cnt = 0;
            while (o_busy[0] && cnt < 40) begin
                if (cnt < 4) begin
                    a_we = 1'b1; a_re = 1'b1; a_ra = 4'd1;
                end else begin
                    a_we = 1'b0; a_re = 1'b0;
                end
                tick();
                cnt++;
                if (cnt < 4) chk("busy_vld", 32'(o_vld[0]), 32'h0);
            end
            a_we = 1'b0; a_re = 1'b0;
            chk("clr_busy_len", 32'(cnt), 32'd16);
        end
        read_a(4'd1);
        chk("clr_addr1", 32'(o_rd[0]), 32'hA);
        read_a(4'd3);
        chk("clr_addr3", 32'(o_rd[1]), 32'hA);

        // Reset in the middle of a clear restarts it from word 0.
        a_wa = 4'd15; a_wd = 4'h4; a_we = 1'b1;
        tick();
        a_we = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        repeat (5) tick();
        a_rst = 1'b1;
        tick();
        a_rst = 1'b0;
        chk("rst_mid_busy", 32'(o_busy[0]), 32'h1);
        count_busy(0, "rst_mid_len");
        for (int a = 0; a < 16; a++) begin
            read_a(4'(a));
            chk("rst_mid_rd", 32'(o_rd[0]), 32'hA);
        end

        // No clear on reset: contents survive, reset only zeroes the read register.
        b_wa = 4'd0; b_wd = 4'h9; b_we = 1'b1;
        tick();
        b_wa = 4'd5; b_wd = 4'h6;
        tick();
        b_we = 1'b0;
        read_b(4'd5);
        chk("nc_pre_rd", 32'(o_rd[2]), 32'h6);
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        chk("nc_busy", 32'(o_busy[2]), 32'h0);
        chk("nc_rd_zero", 32'(o_rd[2]), 32'h0);
        read_b(4'd0);
        chk("nc_survive", 32'(o_rd[2]), 32'h9);
        chk("nc_vld", 32'(o_vld[2]), 32'h1);

        // Reset aborts a clear: early words cleared, later ones untouched.
        b_clr = 1'b1;
        tick();
        b_clr = 1'b0;
        chk("nc_clr_busy", 32'(o_busy[2]), 32'h1);
        repeat (2) tick();
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0;
        chk("nc_abort_busy", 32'(o_busy[2]), 32'h0);
        read_b(4'd0);
        chk("nc_abort_w0", 32'(o_rd[2]), 32'h3);
        read_b(4'd5);
        chk("nc_abort_w5", 32'(o_rd[2]), 32'h6);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
